// File: rtl/jrb8_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jrb8_pkg: shared widths and enums for the jrb8 fetch front end.  Rev 1.0
// ---------------------------------------------------------------------------
package jrb8_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  typedef enum logic [2:0] {
    RD_NONE = 3'd0,
    RD_PCC  = 3'd1,
    RD_JMP  = 3'd2,
    RD_CALL = 3'd3,
    RD_RET  = 3'd4
  } redir_t;

  // Redirects that replace the PC outright (everything except a plain advance)
  function automatic logic is_jump(input redir_t k);
    return (k == RD_JMP) || (k == RD_CALL) || (k == RD_RET);
  endfunction
endpackage
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_stack: circular LIFO of return addresses; a push when full drops the oldest.  Rev 1.0
// ---------------------------------------------------------------------------
module pc_stack
  import jrb8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int                c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(DEPTH);

  logic [ADDR_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_top;
  logic [c_ptr_w:0]   r_count;
  logic [c_ptr_w-1:0] w_top_inc;

  assign w_top_inc = r_top + 1'b1;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_top_inc] <= i_data;
  end

  // r_top resets to the last slot so the first push lands in slot 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_top   <= '1;
      r_count <= '0;
    end else if (i_push) begin
      r_top <= w_top_inc;
      if (!o_full) r_count <= r_count + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_top   <= r_top - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  assign o_full  = (r_count == c_depth);
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_top];
endmodule
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch: PC register and byte fetch FSM; PC_STACK_EN adds call/ret return stack.  Rev 1.0
// ---------------------------------------------------------------------------
module pc_fetch
  import jrb8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
  parameter int                STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pcc,
  input  logic              i_jmp,
  input  logic [ADDR_W-1:0] i_jmp_addr,
  input  logic              i_call,
  input  logic              i_ret,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_fetch_data,
  output logic              o_fetch_valid,
  output logic              o_stall,
  output logic              o_stack_err
);
  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_mem_req;
  logic [DATA_W-1:0] r_fetch_data;
  logic              r_fetch_valid;
  logic              r_pend_valid;
  redir_t            r_pend_kind;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_stack_err;

  redir_t            w_rd;
  redir_t            w_exec;
  logic [ADDR_W-1:0] w_exec_addr;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_ack_edge;
  logic              w_stk_err;

  if ((STACK_DEPTH < 2) || (STACK_DEPTH > 8) || ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0))
  begin : g_bad_depth
    $error("pc_fetch: STACK_DEPTH must be a power of two in 2..8");
  end

  assign w_pc_inc   = r_pc + 1'b1;
  assign w_ack_edge = (r_state == ST_REQ) && r_mem_req && i_mem_ack;

  always_comb begin
    w_rd = RD_NONE;
`ifdef PC_STACK_EN
    if (i_ret)                w_rd = RD_RET;
    else if (i_call)          w_rd = RD_CALL;
    else if (i_jmp)           w_rd = RD_JMP;
    else if (i_pcc)           w_rd = RD_PCC;
`else
    if (i_call || i_jmp)      w_rd = RD_JMP;
    else if (i_pcc)           w_rd = RD_PCC;
`endif
  end

  // A redirect arriving on the ack edge itself supersedes any older pending one
  always_comb begin
    w_exec      = RD_NONE;
    w_exec_addr = i_jmp_addr;
    if (r_state == ST_VALID) begin
      w_exec = w_rd;
    end else if (w_ack_edge) begin
      if (is_jump(w_rd)) begin
        w_exec = w_rd;
      end else if (r_pend_valid) begin
        w_exec      = r_pend_kind;
        w_exec_addr = r_pend_addr;
      end
    end
  end

`ifdef PC_STACK_EN
  logic              w_push;
  logic              w_pop;
  logic              w_stk_full;
  logic              w_stk_empty;
  logic [ADDR_W-1:0] w_stk_top;

  assign w_push    = (w_exec == RD_CALL);
  assign w_pop     = (w_exec == RD_RET);
  assign w_stk_err = (w_push && w_stk_full) || (w_pop && w_stk_empty);

  pc_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_data  (w_stk_top),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );
`else
  logic w_unused;
  assign w_unused  = i_ret;
  assign w_stk_err = 1'b0;
`endif

  always_comb begin
    w_next_pc = r_pc;
    case (w_exec)
      RD_PCC:          w_next_pc = w_pc_inc;
      RD_JMP, RD_CALL: w_next_pc = w_exec_addr;
`ifdef PC_STACK_EN
      RD_RET:          w_next_pc = w_stk_empty ? RESET_PC : w_stk_top;
`endif
      default:         w_next_pc = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_mem_req     <= 1'b0;
      r_fetch_data  <= '0;
      r_fetch_valid <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_kind   <= RD_NONE;
      r_pend_addr   <= '0;
      r_stack_err   <= 1'b0;
    end else begin
      r_stack_err <= w_stk_err;
      case (r_state)
        ST_IDLE: begin
          r_state   <= ST_REQ;
          r_mem_req <= 1'b1;
        end
        ST_REQ: begin
          if (w_ack_edge) begin
            r_mem_req <= 1'b0;
            if (w_exec != RD_NONE) begin
              // Stale data: take the new PC and leave one idle cycle before reissuing
              r_pc         <= w_next_pc;
              r_pend_valid <= 1'b0;
            end else begin
              r_fetch_data  <= i_mem_rdata;
              r_fetch_valid <= 1'b1;
              r_state       <= ST_VALID;
            end
          end else begin
            if (!r_mem_req) r_mem_req <= 1'b1;
            if (is_jump(w_rd)) begin
              r_pend_valid <= 1'b1;
              r_pend_kind  <= w_rd;
              r_pend_addr  <= i_jmp_addr;
            end
          end
        end
        ST_VALID: begin
          if (w_exec != RD_NONE) begin
            r_pc          <= w_next_pc;
            r_fetch_valid <= 1'b0;
            r_mem_req     <= 1'b1;
            r_state       <= ST_REQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_pc;
  assign o_pc          = r_pc;
  assign o_fetch_data  = r_fetch_data;
  assign o_fetch_valid = r_fetch_valid;
  assign o_stall       = ~r_fetch_valid;
  assign o_stack_err   = r_stack_err;
endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_fetch: directed vector bench for pc_fetch with a fixed-latency memory model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_pcc = 1'b0, i_jmp = 1'b0, i_call = 1'b0, i_ret = 1'b0;
  logic [15:0] i_jmp_addr = 16'h0000;
  logic        i_mem_ack;
  logic [7:0]  i_mem_rdata;
  logic        o_mem_req, o_fetch_valid, o_stall, o_stack_err;
  logic [15:0] o_mem_addr, o_pc;
  logic [7:0]  o_fetch_data;

  logic        m_ack = 1'b0, t_ack = 1'b0, ovr_en = 1'b0;
  logic [7:0]  m_rdata = 8'h00, t_rdata = 8'h00, ovr_byte = 8'h00;
  int          lat = 2;
  int          cnt = 0;
  int          n_checks = 0, n_errors = 0;

  typedef struct {
    logic        pcc, jmp, call, ret;
    logic [15:0] addr;
    logic        redir;
    logic [15:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  assign i_mem_ack   = m_ack | t_ack;
  assign i_mem_rdata = t_ack ? t_rdata : m_rdata;

  pc_fetch #(.RESET_PC(16'h0000), .STACK_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pcc         (i_pcc),
    .i_jmp         (i_jmp),
    .i_jmp_addr    (i_jmp_addr),
    .i_call        (i_call),
    .i_ret         (i_ret),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_ack     (i_mem_ack),
    .i_mem_rdata   (i_mem_rdata),
    .o_pc          (o_pc),
    .o_fetch_data  (o_fetch_data),
    .o_fetch_valid (o_fetch_valid),
    .o_stall       (o_stall),
    .o_stack_err   (o_stack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Memory answers 'lat' cycles after it first sees a request
  always @(negedge clk) begin
    m_ack = 1'b0;
    if (reset || !o_mem_req) cnt = 0;
    else begin
      cnt = cnt + 1;
      if (cnt >= lat) begin
        m_ack   = 1'b1;
        m_rdata = ovr_en ? ovr_byte : mem_byte(o_mem_addr);
        cnt     = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 50; k++) begin
      if (o_fetch_valid === 1'b1) return;
      @(negedge clk);
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: fetch_valid timeout got 0 expected 1", name);
  endtask

  task automatic add(input logic p, input logic j, input logic c, input logic r,
                     input logic [15:0] a, input logic rd, input logic [15:0] e, input logic er);
    vecs[nv] = '{p, j, c, r, a, rd, e, er};
    nv++;
  endtask

  task automatic apply(input vec_t v, input int idx);
    wait_valid($sformatf("row%0d pre", idx));
    i_pcc = v.pcc; i_jmp = v.jmp; i_call = v.call; i_ret = v.ret; i_jmp_addr = v.addr;
    @(negedge clk);
    i_pcc = 1'b0; i_jmp = 1'b0; i_call = 1'b0; i_ret = 1'b0;
    chk($sformatf("row%0d pc", idx), o_pc, v.exp_pc);
    chk($sformatf("row%0d stack_err", idx), 16'(o_stack_err), 16'(v.exp_err));
    if (v.redir) begin
      chk($sformatf("row%0d valid_clr", idx), 16'(o_fetch_valid), 16'h0);
      chk($sformatf("row%0d mem_req", idx), 16'(o_mem_req), 16'h1);
      chk($sformatf("row%0d mem_addr", idx), o_mem_addr, v.exp_pc);
      @(negedge clk);
      chk($sformatf("row%0d err_pulse_end", idx), 16'(o_stack_err), 16'h0);
      wait_valid($sformatf("row%0d fetch", idx));
      chk($sformatf("row%0d data", idx), 16'(o_fetch_data), 16'(mem_byte(v.exp_pc)));
    end else begin
      chk($sformatf("row%0d valid_hold", idx), 16'(o_fetch_valid), 16'h1);
      chk($sformatf("row%0d no_req", idx), 16'(o_mem_req), 16'h0);
    end
  endtask

  initial begin
    logic [15:0] p;
    // Vectors applied from VALID; expected PCs worked out by hand
    add(1, 0, 0, 0, 16'h0000, 1, 16'h0001, 0);
    add(1, 1, 0, 0, 16'h0040, 1, 16'h0040, 0);
    add(0, 1, 0, 0, 16'hFFFF, 1, 16'hFFFF, 0);
    add(1, 0, 0, 0, 16'h0000, 1, 16'h0000, 0);
    add(0, 1, 0, 0, 16'h0100, 1, 16'h0100, 0);
`ifndef PC_STACK_EN
    add(0, 0, 1, 0, 16'h0300, 1, 16'h0300, 0);
    add(0, 0, 0, 1, 16'h0700, 0, 16'h0300, 0);
    add(1, 0, 0, 1, 16'h0700, 1, 16'h0301, 0);
`else
    add(0, 1, 0, 0, 16'h0010, 1, 16'h0010, 0);
    add(0, 0, 1, 0, 16'h0200, 1, 16'h0200, 0);
    add(0, 0, 0, 1, 16'h0000, 1, 16'h0011, 0);
    add(0, 0, 0, 1, 16'h0000, 1, 16'h0000, 1);
    add(0, 1, 0, 0, 16'h1000, 1, 16'h1000, 0);
    add(0, 0, 1, 0, 16'h2000, 1, 16'h2000, 0);
    add(0, 0, 1, 0, 16'h3000, 1, 16'h3000, 0);
    add(0, 0, 1, 0, 16'h4000, 1, 16'h4000, 0);
    add(0, 0, 1, 0, 16'h5000, 1, 16'h5000, 0);
    add(0, 0, 1, 0, 16'h6000, 1, 16'h6000, 1);
    add(0, 1, 0, 1, 16'h7777, 1, 16'h5001, 0);
    add(0, 0, 0, 1, 16'h0000, 1, 16'h4001, 0);
    add(0, 0, 0, 1, 16'h0000, 1, 16'h3001, 0);
    add(0, 0, 0, 1, 16'h0000, 1, 16'h2001, 0);
    add(1, 0, 1, 1, 16'h0123, 1, 16'h0000, 1);
`endif

    repeat (3) @(negedge clk);
    chk("reset pc", o_pc, 16'h0000);
    chk("reset mem_req", 16'(o_mem_req), 16'h0);
    chk("reset valid", 16'(o_fetch_valid), 16'h0);
    chk("reset stall", 16'(o_stall), 16'h1);
    chk("reset data", 16'(o_fetch_data), 16'h0000);
    chk("reset stack_err", 16'(o_stack_err), 16'h0);

    // A stray ack during the IDLE cycle must not be taken as fetch data
    reset = 1'b0; t_ack = 1'b1; t_rdata = 8'hEE;
    @(negedge clk);
    t_ack = 1'b0;
    chk("idle->req mem_req", 16'(o_mem_req), 16'h1);
    chk("idle ack ignored", 16'(o_fetch_valid), 16'h0);
    chk("first mem_addr", o_mem_addr, 16'h0000);

    wait_valid("first fetch");
    chk("first data", 16'(o_fetch_data), 16'h00A5);
    chk("first pc", o_pc, 16'h0000);
    chk("first stall", 16'(o_stall), 16'h0);
    chk("first mem_req low", 16'(o_mem_req), 16'h0);

    for (int i = 0; i < nv; i++) apply(vecs[i], i);

    // Pending jump while a request is outstanding; pcc in REQ is ignored
    p = vecs[nv-1].exp_pc + 16'h0001;
    wait_valid("pend pre");
    lat = 4;
    i_pcc = 1'b1;
    @(negedge clk);
    ovr_en = 1'b1; ovr_byte = 8'h11;
    @(negedge clk);
    i_pcc = 1'b0;
    chk("pcc in req ignored", o_pc, p);
    i_jmp = 1'b1; i_jmp_addr = 16'h1234;
    @(negedge clk);
    i_jmp = 1'b0;
    chk("pend pc held", o_pc, p);
    chk("pend mem_req held", 16'(o_mem_req), 16'h1);
    repeat (2) @(negedge clk);
    chk("pend pc on ack", o_pc, 16'h1234);
    chk("pend gap mem_req", 16'(o_mem_req), 16'h0);
    chk("pend data dropped", 16'(o_fetch_valid), 16'h0);
    ovr_en = 1'b0; lat = 2;
    @(negedge clk);
    chk("pend reissue req", 16'(o_mem_req), 16'h1);
    chk("pend reissue addr", o_mem_addr, 16'h1234);
    wait_valid("pend fetch");
    chk("pend new data", 16'(o_fetch_data), 16'(mem_byte(16'h1234)));

    // Jump landing on the same edge as the ack
    i_pcc = 1'b1;
    @(negedge clk);
    i_pcc = 1'b0;
    chk("coinc pc", o_pc, 16'h1235);
    @(negedge clk);
    i_jmp = 1'b1; i_jmp_addr = 16'h0500;
    @(negedge clk);
    i_jmp = 1'b0;
    chk("coinc pc on ack", o_pc, 16'h0500);
    chk("coinc gap", 16'(o_mem_req), 16'h0);
    chk("coinc data dropped", 16'(o_fetch_valid), 16'h0);
    wait_valid("coinc fetch");
    chk("coinc data", 16'(o_fetch_data), 16'(mem_byte(16'h0500)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter STACK_DEPTH, 4, return-stack entries (PC_STACK_EN only); power of two, 2..8.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 pcc  in  1  advance request from control unit; PC increments by one.
REQ-006 jmp  in  1  load jmp_addr into PC.
REQ-007 jmp_addr  in  16  jump/call target.
REQ-008 call  in  1  push PC+1 and load jmp_addr (PC_STACK_EN).
REQ-009 ret  in  1  pop return address into PC (PC_STACK_EN).
REQ-010 mem_req  out  1  memory read request.
REQ-011 mem_addr  out  16  read address; equals pc whenever mem_req=1.
REQ-012 mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
REQ-013 mem_rdata  in  8  read data.
REQ-014 pc  out  16  current program counter.
REQ-015 fetch_data  out  8  byte at pc for the instruction register.
REQ-016 fetch_valid  out  1  fetch_data is valid for current pc.
REQ-017 stall  out  1  equals ~fetch_valid.
REQ-018 stack_err  out  1  one-cycle pulse on stack overflow/underflow.

Function
REQ-019 FSM states: IDLE, REQ, VALID; IDLE exists only for the first cycle after reset, then unconditionally to REQ.
REQ-020 REQ: mem_req=1, held until mem_ack; on mem_ack capture mem_rdata into fetch_data, fetch_valid=1 next cycle, go VALID.
REQ-021 VALID: mem_req=0; fetch_data and fetch_valid hold until a redirect (pcc, jmp, call, ret).
REQ-022 Redirect priority: ret > call > jmp > pcc; only the highest is acted on per cycle.
REQ-023 In VALID, a redirect updates pc next cycle, clears fetch_valid same edge, goes REQ; fetch latency = 1 cycle + memory latency.
REQ-024 pcc while fetch_valid=0 is ignored (no increment, no record).
REQ-025 jmp/call/ret in REQ: mem_req stays high until mem_ack (no abort); the redirect is latched as pending (later one overwrites earlier), returned data is discarded, pc updated on the ack edge, FSM stays REQ and reissues with mem_req low for exactly one cycle.
REQ-026 Redirect coincident with mem_ack in REQ: treated as pending per REQ-025; data discarded.
REQ-027 PC arithmetic modulo 2^16: 16'hFFFF + 1 = 16'h0000, no flag.
REQ-028 mem_addr driven from pc register, never combinationally from inputs.

Reset
REQ-029 Reset: pc=RESET_PC, state=IDLE, mem_req=0, fetch_valid=0, stall=1, fetch_data=8'h00, stack_err=0, stack empty, pending cleared.
REQ-030 Reset during an outstanding request abandons it; a mem_ack arriving after reset release while in IDLE is ignored.

Configuration
REQ-031 Macro PC_STACK_EN: when defined, call pushes pc+1 (mod 2^16) and loads jmp_addr; ret pops top into pc.
REQ-032 With PC_STACK_EN: push when full overwrites oldest entry and pulses stack_err; pop when empty loads RESET_PC and pulses stack_err.
REQ-033 Without PC_STACK_EN: call behaves exactly as jmp, ret ignored, stack_err tied 0, no stack storage.

Structure
REQ-034 Shared package jrb8_pkg holds ADDR_W=16, DATA_W=8 and the fetch FSM state enum.
REQ-035 Return stack is sub-module pc_stack (push, pop, full, empty, data), instantiated only under PC_STACK_EN.

Verification
REQ-036 Reset, memory acks 2 cycles after each req with 8'hA5 -> mem_addr=0000, fetch_valid=1, fetch_data=A5; pcc -> pc=0001, new req.
REQ-037 pc=FFFF valid, pcc -> pc=0000, mem_addr=0000.
REQ-038 jmp to 1234 while in REQ, ack returns 8'h11 -> 11 discarded, one-cycle mem_req gap, next request at 1234.
REQ-039 pcc, jmp(0040) same cycle in VALID -> pc=0040; pcc with fetch_valid=0 -> pc unchanged.
REQ-040 PC_STACK_EN: at pc=0010 call 0200 -> pc=0200; ret -> pc=0011; ret on empty -> pc=RESET_PC, stack_err pulse.
REQ-041 PC_STACK_EN: 5 calls with STACK_DEPTH=4 -> stack_err on 5th; 4 rets return last four pushes in LIFO order.
